// File: rtl/mb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mb_pkg
//  Description : Shared constants for the Math Box sequencer: sequencer state
//                encoding, default datapath widths and watchdog depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package mb_pkg;

    // Default datapath widths
    localparam int MB_PC_W          = 8;
    localparam int MB_DATA_W        = 8;
    localparam int MB_ADDR_W        = 5;

    // Microcycles a program may execute before the watchdog aborts it
    localparam int MB_WDOG_CYCLES   = 1024;

    // Sequencer state encoding
    localparam int                    MB_STATE_W = 1;
    localparam logic [MB_STATE_W-1:0] MB_IDLE    = 1'b0;
    localparam logic [MB_STATE_W-1:0] MB_RUN     = 1'b1;

endpackage : mb_pkg
`default_nettype wire

// File: rtl/mb_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : mb_watchdog
//  Description : Counts executed microcycles of the running program. The
//                expire pulse fires on the execute edge that would complete
//                the WDOG_CYCLES-th microcycle. A clear restarts the count.
//  Revision    : 1.0 - initial release
// ============================================================================
module mb_watchdog
    import mb_pkg::*;
#(
    parameter int WDOG_CYCLES = MB_WDOG_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic exec_i,
    output logic expire_o
);

    localparam int               CNT_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The current execute edge is the last permitted one
    assign expire_o = exec_i & (cnt_q == CNT_LAST);

    // Count executed microcycles; a new command restarts from zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (exec_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : mb_watchdog
`default_nettype wire

// File: rtl/mb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mb_sequencer
//  Description : Math Box sequencer. Latches CPU command writes, loads the
//                microcode PC from the start map, steps the PC once per
//                two-clock microcycle (phase 0 fetch, phase 1 execute) and
//                reports Begin_NOT / Status to the CPU read path.
//                Optional feature macro: MB_WATCHDOG_EN (aborts a program
//                after WDOG_CYCLES executed microcycles, sets wdog_err).
//  Revision    : 1.0 - initial release
// ============================================================================
module mb_sequencer
    import mb_pkg::*;
#(
    parameter int PC_W        = MB_PC_W,
    parameter int DATA_W      = MB_DATA_W,
    parameter int ADDR_W      = MB_ADDR_W,
    parameter int WDOG_CYCLES = MB_WDOG_CYCLES
) (
    input  logic              clk_6MHz,
    input  logic              Reset_NOT,
    input  logic              mb_wr,
    input  logic [ADDR_W-1:0] mb_addr,
    input  logic [DATA_W-1:0] mb_din,
    output logic [ADDR_W-1:0] map_addr,
    input  logic [PC_W-1:0]   map_data,
    input  logic              ucode_stop,
    input  logic              ucode_jmp,
    input  logic [PC_W-1:0]   ucode_jmp_addr,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] data_latch,
    output logic              alu_en,
    output logic              Begin_NOT,
    output logic              Status,
    output logic              wdog_err
);

    logic [MB_STATE_W-1:0] state_q;
    logic [MB_STATE_W-1:0] state_d;
    logic                  ph_q;
    logic                  ph_d;
    logic [PC_W-1:0]       pc_q;
    logic [PC_W-1:0]       pc_d;
    logic [DATA_W-1:0]     data_q;
    logic [DATA_W-1:0]     data_d;
    logic                  begin_n_q;
    logic                  begin_n_d;
    logic                  wdog_err_q;
    logic                  wdog_err_d;

    // Execute edge of a running program not preempted by a new command
    logic                  exec_edge;
    logic                  wdog_expire;

    assign exec_edge = (state_q == MB_RUN) & ph_q & ~mb_wr;

`ifdef MB_WATCHDOG_EN
    mb_watchdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_watchdog (
        .clk      (clk_6MHz),
        .rst_n    (Reset_NOT),
        .clr_i    (mb_wr),
        .exec_i   (exec_edge & ~ucode_stop),
        .expire_o (wdog_expire)
    );
`else
    localparam int unused_wdog_cycles = WDOG_CYCLES;
    assign wdog_expire = 1'b0;
`endif

    // Start map is addressed straight from the CPU write address
    assign map_addr = mb_addr;

    // State register
    always_ff @(posedge clk_6MHz or negedge Reset_NOT) begin
        if (!Reset_NOT) begin
            state_q <= MB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a write always (re)starts; STOP or watchdog abort halt
    always_comb begin
        state_d = state_q;
        if (mb_wr) begin
            state_d = MB_RUN;
        end else if (exec_edge && (ucode_stop || wdog_expire)) begin
            state_d = MB_IDLE;
        end
    end

    // FSM outputs: ALU enabled on the execute phase, busy while running
    always_comb begin
        alu_en = 1'b0;
        Status = 1'b0;
        if (state_q == MB_RUN) begin
            alu_en = ph_q;
            Status = 1'b1;
        end
    end

    // Datapath next values: command latch, PC sequencing, phase and flags
    always_comb begin
        ph_d       = 1'b0;
        pc_d       = pc_q;
        data_d     = data_q;
        begin_n_d  = begin_n_q;
        wdog_err_d = wdog_err_q;
        if (mb_wr) begin
            data_d     = mb_din;
            pc_d       = map_data;
            begin_n_d  = 1'b0;
            wdog_err_d = 1'b0;
        end else if (state_q == MB_RUN) begin
            ph_d = ~ph_q;
            if (ph_q) begin
                begin_n_d = 1'b1;
                // STOP holds the PC; an abort also holds it
                if (!ucode_stop) begin
                    if (wdog_expire) begin
                        wdog_err_d = 1'b1;
                    end else if (ucode_jmp) begin
                        pc_d = ucode_jmp_addr;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_6MHz or negedge Reset_NOT) begin
        if (!Reset_NOT) begin
            ph_q       <= 1'b0;
            pc_q       <= '0;
            data_q     <= '0;
            begin_n_q  <= 1'b1;
            wdog_err_q <= 1'b0;
        end else begin
            ph_q       <= ph_d;
            pc_q       <= pc_d;
            data_q     <= data_d;
            begin_n_q  <= begin_n_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign pc         = pc_q;
    assign data_latch = data_q;
    assign Begin_NOT  = begin_n_q;
    assign wdog_err   = wdog_err_q;

endmodule : mb_sequencer
`default_nettype wire

// File: tb/tb_mb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mb_sequencer
//  Description : Directed self-checking bench for mb_sequencer. A small
//                microcode ROM model answers STOP/JUMP from the DUT PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mb_sequencer;

    logic       clk_6MHz;
    logic       Reset_NOT;
    logic       mb_wr;
    logic [4:0] mb_addr;
    logic [7:0] mb_din;
    logic [4:0] map_addr;
    logic [7:0] map_data;
    logic       ucode_stop;
    logic       ucode_jmp;
    logic [7:0] ucode_jmp_addr;
    logic [7:0] pc;
    logic [7:0] data_latch;
    logic       alu_en;
    logic       Begin_NOT;
    logic       Status;
    logic       wdog_err;

    // ROM model controls
    logic       stop_en;
    logic [7:0] stop_pc;
    logic       jmp_en;
    logic [7:0] jmp_pc;
    logic [7:0] jmp_to;

    int n_checks;
    int n_errors;

    // Trace results
    int         n_exec;
    int         n_beg;
    int         n_stat;
    logic [7:0] exec_pc [0:31];

    mb_sequencer #(
        .PC_W        (8),
        .DATA_W      (8),
        .ADDR_W      (5),
        .WDOG_CYCLES (8)
    ) dut (
        .clk_6MHz       (clk_6MHz),
        .Reset_NOT      (Reset_NOT),
        .mb_wr          (mb_wr),
        .mb_addr        (mb_addr),
        .mb_din         (mb_din),
        .map_addr       (map_addr),
        .map_data       (map_data),
        .ucode_stop     (ucode_stop),
        .ucode_jmp      (ucode_jmp),
        .ucode_jmp_addr (ucode_jmp_addr),
        .pc             (pc),
        .data_latch     (data_latch),
        .alu_en         (alu_en),
        .Begin_NOT      (Begin_NOT),
        .Status         (Status),
        .wdog_err       (wdog_err)
    );

    initial clk_6MHz = 1'b0;
    always #5 clk_6MHz = ~clk_6MHz;

    // Microcode ROM model: STOP / JUMP bits decoded from the current PC
    always_comb begin
        ucode_stop     = stop_en && (pc == stop_pc);
        ucode_jmp      = jmp_en && (pc == jmp_pc);
        ucode_jmp_addr = jmp_to;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the active edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_6MHz);
            #1;
        end
    endtask

    // One-clock command write; returns just after the capturing edge
    task automatic mb_write(input logic [4:0] a, input logic [7:0] d, input logic [7:0] start);
        mb_addr  = a;
        mb_din   = d;
        map_data = start;
        mb_wr    = 1'b1;
        step(1);
        mb_wr    = 1'b0;
    endtask

    // Observe n samples (current one first), logging executed PCs
    task automatic trace(input int n);
        n_exec = 0;
        n_beg  = 0;
        n_stat = 0;
        for (int k = 0; k < n; k++) begin
            if (alu_en) begin
                if (n_exec < 32) exec_pc[n_exec] = pc;
                n_exec++;
            end
            if (!Begin_NOT) n_beg++;
            if (Status) n_stat++;
            step(1);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        Reset_NOT = 1'b0;
        mb_wr     = 1'b0;
        mb_addr   = '0;
        mb_din    = '0;
        map_data  = '0;
        stop_en   = 1'b0;
        stop_pc   = '0;
        jmp_en    = 1'b0;
        jmp_pc    = '0;
        jmp_to    = '0;

        // Reset values
        step(2);
        check("rst_pc",     pc,         8'h00);
        check("rst_data",   data_latch, 8'h00);
        check("rst_begin",  Begin_NOT,  1'b1);
        check("rst_status", Status,     1'b0);
        check("rst_alu",    alu_en,     1'b0);
        check("rst_wdog",   wdog_err,   1'b0);
        #2 Reset_NOT = 1'b1;
        step(1);

        // Basic run 0x10..0x13 with STOP at 0x13
        mb_addr = 5'd3;
        #1;
        check("t2_map_addr", map_addr, 5'd3);
        stop_en = 1'b1;
        stop_pc = 8'h13;
        mb_write(5'd3, 8'hA5, 8'h10);
        check("t2_start_pc",    pc,         8'h10);
        check("t2_start_data",  data_latch, 8'hA5);
        check("t2_start_begin", Begin_NOT,  1'b0);
        check("t2_start_alu",   alu_en,     1'b0);
        step(1);
        check("t2_first_alu",   alu_en,     1'b1);
        step(1);
        check("t2_begin_rel",   Begin_NOT,  1'b1);
        mb_write(5'd3, 8'hA5, 8'h10);
        trace(20);
        check("t2_n_exec", n_exec, 4);
        check("t2_pc0", exec_pc[0], 8'h10);
        check("t2_pc1", exec_pc[1], 8'h11);
        check("t2_pc2", exec_pc[2], 8'h12);
        check("t2_pc3", exec_pc[3], 8'h13);
        check("t2_n_begin",  n_beg,  2);
        check("t2_n_status", n_stat, 8);
        check("t2_end_pc",     pc,     8'h13);
        check("t2_end_status", Status, 1'b0);
        check("t2_end_data",   data_latch, 8'hA5);

        // JUMP 0x11 -> 0x40, STOP at 0x40
        stop_pc = 8'h40;
        jmp_en  = 1'b1;
        jmp_pc  = 8'h11;
        jmp_to  = 8'h40;
        mb_write(5'd4, 8'h3C, 8'h10);
        trace(20);
        check("t3_n_exec", n_exec, 3);
        check("t3_pc0", exec_pc[0], 8'h10);
        check("t3_pc1", exec_pc[1], 8'h11);
        check("t3_pc2", exec_pc[2], 8'h40);
        check("t3_end_status", Status, 1'b0);

        // STOP and JUMP on the same microword: STOP wins
        jmp_pc = 8'h40;
        jmp_to = 8'h55;
        mb_write(5'd5, 8'h01, 8'h40);
        trace(12);
        check("t3b_n_exec", n_exec, 1);
        check("t3b_pc",     pc,     8'h40);
        check("t3b_status", Status, 1'b0);
        jmp_en = 1'b0;

        // PC wrap 0xFF -> 0x00 -> 0x01
        stop_pc = 8'h01;
        mb_write(5'd6, 8'h02, 8'hFF);
        trace(16);
        check("t4_n_exec", n_exec, 3);
        check("t4_pc0", exec_pc[0], 8'hFF);
        check("t4_pc1", exec_pc[1], 8'h00);
        check("t4_pc2", exec_pc[2], 8'h01);
        check("t4_end_status", Status, 1'b0);

        // Restart during RUN at pc 0x12
        stop_pc = 8'h31;
        mb_write(5'd7, 8'h11, 8'h10);
        step(4);
        check("t5_pre_pc",     pc,        8'h12);
        check("t5_pre_begin",  Begin_NOT, 1'b1);
        check("t5_pre_status", Status,    1'b1);
        mb_write(5'd8, 8'h22, 8'h30);
        check("t5_pc",     pc,         8'h30);
        check("t5_begin",  Begin_NOT,  1'b0);
        check("t5_status", Status,     1'b1);
        check("t5_data",   data_latch, 8'h22);
        trace(12);
        check("t5_n_exec", n_exec, 2);
        check("t5_pc1", exec_pc[1], 8'h31);

        // Write coinciding with a STOP execute phase: the start wins
        stop_pc = 8'h10;
        mb_write(5'd9, 8'h33, 8'h10);
        step(1);
        check("t5b_stop_exec", alu_en && ucode_stop, 1'b1);
        stop_pc = 8'h50;
        mb_write(5'd9, 8'h44, 8'h50);
        check("t5b_pc",     pc,        8'h50);
        check("t5b_status", Status,    1'b1);
        check("t5b_begin",  Begin_NOT, 1'b0);
        trace(8);
        check("t5b_n_exec", n_exec, 1);
        check("t5b_end",    Status, 1'b0);

        // Program without STOP: watchdog abort or free run
        stop_en = 1'b0;
        mb_write(5'd10, 8'h55, 8'h20);
        trace(30);
`ifdef MB_WATCHDOG_EN
        check("t6_n_exec", n_exec,   8);
        check("t6_status", Status,   1'b0);
        check("t6_wdog",   wdog_err, 1'b1);
        step(3);
        check("t6_sticky", wdog_err, 1'b1);
        mb_write(5'd10, 8'h55, 8'h20);
        check("t6_clear",  wdog_err, 1'b0);
        check("t6_rerun",  Status,   1'b1);
`else
        check("t6_n_exec", n_exec,   15);
        check("t6_status", Status,   1'b1);
        check("t6_wdog",   wdog_err, 1'b0);
        check("t6_pc",     pc,       8'h2F);
`endif

        // Asynchronous reset in the middle of a run
        mb_write(5'd11, 8'h66, 8'h80);
        step(3);
        #2 Reset_NOT = 1'b0;
        #1;
        check("t1_pc",     pc,         8'h00);
        check("t1_data",   data_latch, 8'h00);
        check("t1_begin",  Begin_NOT,  1'b1);
        check("t1_status", Status,     1'b0);
        check("t1_alu",    alu_en,     1'b0);
        check("t1_wdog",   wdog_err,   1'b0);
        step(2);
        check("t1_hold",   Status,     1'b0);
        Reset_NOT = 1'b1;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mb_sequencer
`default_nettype wire
